// File: rtl/instruction_fetch_pkg.sv
// Shared widths and FSM state type for the SRM instruction fetch unit.
package srm_fetch_pkg;
  localparam int PC_W    = 9;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read port: the fetch unit is the master, the memory the slave.
interface instruction_fetch_if;
  import srm_fetch_pkg::*;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_rd;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_ready;

  modport master (output mem_addr, output mem_rd, input mem_rdata, input mem_ready);
  modport slave  (input mem_addr, input mem_rd, output mem_rdata, output mem_ready);
endinterface

// File: rtl/instruction_fetch_watchdog.sv
// Fetch timeout counter; instantiated only when FETCH_WATCHDOG_EN is defined.
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  logic [7:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         cnt <= '0;
    else if (clear)    cnt <= '0;
    else if (count_en) cnt <= cnt + 8'd1;
  end

  // Fires on the edge that closes the TIMEOUT_CYCLES-th stalled READ cycle.
  assign expired = count_en && (cnt == 8'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/instruction_fetch.sv
// PC register and instruction fetch FSM for the Simple RISC Machine.
// Optional fetch timeout compiled in with `define FETCH_WATCHDOG_EN.
module instruction_fetch
  import srm_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC       = 9'h000,
  parameter int              TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_W-1:0]      next_pc,
  input  logic                 load_pc,
  input  logic                 fetch_req,
  instruction_fetch_if.master  mem,
  output logic [PC_W-1:0]      pc,
  output logic [INSTR_W-1:0]   IR,
  output logic                 ir_valid,
  output logic                 busy,
  output logic                 fetch_err
);
  fetch_state_t    state;
  logic [PC_W-1:0] addr_q;
  logic            accept;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  assign accept       = fetch_req && (state == IDLE || state == DONE);
  assign busy         = (state == READ);
  assign ir_valid     = (state == DONE);
  assign mem.mem_rd   = (state == READ);
  assign mem.mem_addr = addr_q;

`ifdef FETCH_WATCHDOG_EN
  logic wd_expired;

  fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .count_en (state == READ && !mem.mem_ready),
    .expired  (wd_expired)
  );
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      IR     <= '0;
`ifdef FETCH_WATCHDOG_EN
      fetch_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load_pc) pc <= next_pc;
          if (accept) begin
            state  <= READ;
            // A same-edge PC load redirects the fetch to the new PC.
            addr_q <= load_pc ? next_pc : pc;
`ifdef FETCH_WATCHDOG_EN
            fetch_err <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          if (mem.mem_ready) begin
            IR    <= mem.mem_rdata;
            state <= DONE;
          end
`ifdef FETCH_WATCHDOG_EN
          else if (wd_expired) begin
            state     <= IDLE;
            fetch_err <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
